// File: rtl/escalonador_temporizador.sv
// Shared slow timer for the elevator controller.
// Three requesters (0 = door hold, 1 = floor travel, 2 = alarm/overload wait)
// compete for one prescaled timer. Grants rotate round-robin. The owner's
// duration is counted in base ticks, and a one-cycle done pulse is returned
// to the owner when the count expires.
module escalonador_temporizador #(
    parameter int PRESCALE = 67108864,
    parameter int CW       = 4
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic [2:0]      i_req,
    input  logic [3*CW-1:0] i_dur,
    input  logic [2:0]      i_cancel,
    output logic [2:0]      o_grant,
    output logic [2:0]      o_done,
    output logic            o_busy,
    output logic [CW-1:0]   o_remaining
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_grant, w_grant_next;
    logic [2:0]      r_done, w_done_next;
    logic            r_busy, w_busy_next;
    logic [CW-1:0]   r_remaining, w_remaining_next;
    logic [PW-1:0]   r_pcnt, w_pcnt_next;
    logic [1:0]      r_ptr, w_ptr_next;
    logic [1:0]      r_owner, w_owner_next;

    logic [1:0]      w_c1, w_c2, w_pick;
    logic [CW-1:0]   w_dur_arr [3];
    logic [CW-1:0]   w_pick_dur;
    logic            w_tick;
    logic            w_cancel;

    // Next requester index in rotation, wrapping 2 -> 0.
    function automatic logic [1:0] f_inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Split the packed duration bus into one field per requester.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dur
            assign w_dur_arr[gi] = i_dur[gi*CW +: CW];
        end
    endgenerate

    // Round-robin pick: first active request starting from the pointer.
    always_comb begin
        w_c1 = f_inc3(r_ptr);
        w_c2 = f_inc3(w_c1);
        if (i_req[r_ptr])
            w_pick = r_ptr;
        else if (i_req[w_c1])
            w_pick = w_c1;
        else
            w_pick = w_c2;
    end

    assign w_pick_dur = w_dur_arr[w_pick];
    assign w_tick     = (r_state == S_RUN) && (r_pcnt == P_LAST);
    assign w_cancel   = i_cancel[r_owner];

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_done_next      = 3'b000;
        w_remaining_next = r_remaining;
        w_pcnt_next      = r_pcnt;
        w_ptr_next       = r_ptr;
        w_owner_next     = r_owner;

        case (r_state)
            S_IDLE: begin
                if (i_req != 3'b000) begin
                    w_owner_next     = w_pick;
                    w_grant_next     = 3'(3'b001 << w_pick);
                    w_pcnt_next      = '0;
                    w_remaining_next = w_pick_dur;
                    if (w_pick_dur == '0) begin
                        // Zero duration completes in the grant cycle itself.
                        w_state_next = S_DONE;
                        w_done_next  = 3'(3'b001 << w_pick);
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (w_cancel) begin
                    // Abort beats a coincident tick: no done is reported.
                    w_state_next     = S_IDLE;
                    w_grant_next     = 3'b000;
                    w_remaining_next = '0;
                    w_pcnt_next      = '0;
                    w_ptr_next       = f_inc3(r_owner);
                end else if (w_tick) begin
                    w_pcnt_next = '0;
                    if (r_remaining > CW'(1)) begin
                        w_remaining_next = r_remaining - CW'(1);
                    end else begin
                        w_remaining_next = '0;
                        w_state_next     = S_DONE;
                        w_done_next      = 3'(3'b001 << r_owner);
                    end
                end else begin
                    w_pcnt_next = r_pcnt + PW'(1);
                end
            end

            S_DONE: begin
                w_state_next     = S_IDLE;
                w_grant_next     = 3'b000;
                w_remaining_next = '0;
                w_pcnt_next      = '0;
                w_ptr_next       = f_inc3(r_owner);
            end

            default: begin
                w_state_next     = S_IDLE;
                w_grant_next     = 3'b000;
                w_remaining_next = '0;
                w_pcnt_next      = '0;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    // State and output registers; reset drops any owner without a done pulse.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'b000;
            r_done      <= 3'b000;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_pcnt      <= '0;
            r_ptr       <= 2'd0;
            r_owner     <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_done      <= w_done_next;
            r_busy      <= w_busy_next;
            r_remaining <= w_remaining_next;
            r_pcnt      <= w_pcnt_next;
            r_ptr       <= w_ptr_next;
            r_owner     <= w_owner_next;
        end
    end

    assign o_grant     = r_grant;
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    assign o_remaining = r_remaining;

endmodule

// File: tb/tb_escalonador_temporizador.sv
// Self-checking bench for escalonador_temporizador with PRESCALE=4, CW=4.
// Expected done pulses (value and cycle) are queued when a grant is observed
// and popped when the DUT raises done.
module tb_escalonador_temporizador;

    localparam int PRESCALE = 4;
    localparam int CW       = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      req = 3'b000;
    logic [3*CW-1:0] dur = '0;
    logic [2:0]      cancel = 3'b000;
    logic [2:0]      grant;
    logic [2:0]      done;
    logic            busy;
    logic [CW-1:0]   remaining;

    typedef struct {
        logic [2:0] val;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    escalonador_temporizador #(.PRESCALE(PRESCALE), .CW(CW)) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_req       (req),
        .i_dur       (dur),
        .i_cancel    (cancel),
        .o_grant     (grant),
        .o_done      (done),
        .o_busy      (busy),
        .o_remaining (remaining)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts done pulses seen in completed cycles.
    always @(posedge clk) if (done !== 3'b000) done_cnt <= done_cnt + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (done !== 3'b000) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (grant !== 3'b000) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        bit ok;
        rst_n = 1'b0; req = 3'b000; cancel = 3'b000; dur = '0;
        step(2);
        n_assert++;
        if ({grant, done, busy, remaining} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b required 0", {grant, done, busy, remaining});
        end
        rst_n = 1'b1;
        step(1);
        // One complete run on requester 0 moves the pointer to 1.
        dur = 12'h001; req = 3'b001;
        step(1);
        n_assert++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b required 001", grant);
        end
        exp_q.push_back('{3'b001, cyc + 4});
        req = 3'b000;
        wait_done(ok);
        n_assert++;
        e = exp_q.pop_front();
        $display("txn reset_first: done=%b cyc=%0d (want %b @%0d)", done, cyc, e.val, e.cyc);
        if (!ok || done !== e.val || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL reset_first_done: got %b @%0d required %b @%0d", done, cyc, e.val, e.cyc);
        end
        step(2);
        // Start requester 1, then reset in the middle of a clock period.
        dur = 12'h050; req = 3'b010;
        step(1);
        n_assert++;
        if (grant !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_run_grant: got %b required 010", grant);
        end
        req = 3'b000;
        step(5);
        #3 rst_n = 1'b0;
        #1;
        n_assert++;
        if ({grant, done, busy, remaining} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b required 0", {grant, done, busy, remaining});
        end
        step(1);
        rst_n = 1'b1;
        // Pointer must be back at 0: requester 0 wins over requester 2.
        dur = 12'h101; req = 3'b101;
        step(1);
        n_assert++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_ptr: got %b required 001", grant);
        end
        exp_q.push_back('{3'b001, cyc + 4});
        req = 3'b000;
        wait_done(ok);
        n_assert++;
        e = exp_q.pop_front();
        $display("txn reset_ptr: done=%b cyc=%0d (want %b @%0d)", done, cyc, e.val, e.cyc);
        if (!ok || done !== e.val || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL reset_ptr_done: got %b @%0d required %b @%0d", done, cyc, e.val, e.cyc);
        end
        step(2);
    endtask

    task automatic test_single();
        exp_t e;
        bit ok;
        dur = 12'h030; req = 3'b010;
        step(1);
        n_assert++;
        if (grant !== 3'b010) begin
            n_fail++;
            $display("FAIL single_grant: got %b required 010", grant);
        end
        exp_q.push_back('{3'b010, cyc + 12});
        req = 3'b000;
        for (int i = 0; i < 12; i++) begin
            n_assert++;
            if (remaining !== 4'(3 - i / 4) || grant !== 3'b010 || done !== 3'b000) begin
                n_fail++;
                $display("FAIL single_remaining[%0d]: got rem=%0d grant=%b done=%b required rem=%0d grant=010 done=000",
                         i, remaining, grant, done, 3 - i / 4);
            end
            step(1);
        end
        wait_done(ok);
        n_assert++;
        e = exp_q.pop_front();
        $display("txn single: done=%b cyc=%0d (want %b @%0d)", done, cyc, e.val, e.cyc);
        if (!ok || done !== e.val || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL single_done: got %b @%0d required %b @%0d", done, cyc, e.val, e.cyc);
        end
        step(1);
        n_assert++;
        if (grant !== 3'b000 || done !== 3'b000) begin
            n_fail++;
            $display("FAIL single_release: got grant=%b done=%b required 000/000", grant, done);
        end
        step(1);
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit ok;
        int last_done;
        logic [2:0] order [4];
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        last_done = 0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1; dur = 12'h111; req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(ok);
            n_assert++;
            if (!ok || grant !== order[k]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b required %b", k, grant, order[k]);
            end
            if (k > 0) begin
                n_assert++;
                if (cyc !== last_done + 2) begin
                    n_fail++;
                    $display("FAIL rr_gap[%0d]: got grant @%0d required @%0d", k, cyc, last_done + 2);
                end
            end
            exp_q.push_back('{order[k], cyc + 4});
            if (k == 3) req = 3'b000;
            wait_done(ok);
            n_assert++;
            e = exp_q.pop_front();
            $display("txn rr[%0d]: done=%b cyc=%0d (want %b @%0d)", k, done, cyc, e.val, e.cyc);
            if (!ok || done !== e.val || cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL rr_done[%0d]: got %b @%0d required %b @%0d", k, done, cyc, e.val, e.cyc);
            end
            last_done = cyc;
            step(1);
        end
        step(1);
    endtask

    task automatic test_cancel();
        exp_t e;
        bit ok;
        int cnt;
        dur = 12'h015; req = 3'b001;
        step(1);
        n_assert++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL cancel_grant: got %b required 001", grant);
        end
        req = 3'b011;
        for (int i = 0; i < 40 && remaining !== 4'd2; i++) step(1);
        n_assert++;
        if (remaining !== 4'd2) begin
            n_fail++;
            $display("FAIL cancel_reach_rem2: got %0d required 2", remaining);
        end
        cancel = 3'b001;
        cnt = done_cnt;
        step(1);
        n_assert++;
        if ({grant, done, remaining} !== 10'b0) begin
            n_fail++;
            $display("FAIL cancel_abort: got grant=%b done=%b rem=%0d required all 0", grant, done, remaining);
        end
        cancel = 3'b000; req = 3'b010;
        step(1);
        n_assert++;
        if (grant !== 3'b010) begin
            n_fail++;
            $display("FAIL cancel_next_grant: got %b required 010", grant);
        end
        exp_q.push_back('{3'b010, cyc + 4});
        req = 3'b000;
        wait_done(ok);
        n_assert++;
        e = exp_q.pop_front();
        $display("txn cancel_next: done=%b cyc=%0d (want %b @%0d)", done, cyc, e.val, e.cyc);
        if (!ok || done !== e.val || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL cancel_next_done: got %b @%0d required %b @%0d", done, cyc, e.val, e.cyc);
        end
        n_assert++;
        if (done_cnt !== cnt) begin
            n_fail++;
            $display("FAIL cancel_no_done: got %0d pulses required %0d", done_cnt, cnt);
        end
        step(2);
    endtask

    task automatic test_zero();
        exp_t e;
        bit ok;
        dur = 12'h000; req = 3'b100;
        step(1);
        n_assert++;
        if (grant !== 3'b100 || done !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_grant_done: got grant=%b done=%b required 100/100", grant, done);
        end
        exp_q.push_back('{3'b100, cyc});
        req = 3'b000;
        wait_done(ok);
        n_assert++;
        e = exp_q.pop_front();
        $display("txn zero: done=%b cyc=%0d (want %b @%0d)", done, cyc, e.val, e.cyc);
        if (!ok || done !== e.val || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL zero_done: got %b @%0d required %b @%0d", done, cyc, e.val, e.cyc);
        end
        step(1);
        n_assert++;
        if ({grant, done, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL zero_idle: got %b required 0", {grant, done, busy});
        end
        step(1);
    endtask

    task automatic test_cancel_tick();
        exp_t e;
        bit ok;
        int cnt;
        dur = 12'h001; req = 3'b001;
        step(1);
        n_assert++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL ct_grant: got %b required 001", grant);
        end
        req = 3'b000;
        step(3);
        n_assert++;
        if (remaining !== 4'd1) begin
            n_fail++;
            $display("FAIL ct_pre: got rem=%0d required 1", remaining);
        end
        cancel = 3'b001;
        cnt = done_cnt;
        step(1);
        n_assert++;
        if ({grant, done, busy, remaining} !== 11'b0) begin
            n_fail++;
            $display("FAIL ct_cancel_wins: got %b required 0", {grant, done, busy, remaining});
        end
        cancel = 3'b000;
        step(3);
        n_assert++;
        if (done_cnt !== cnt) begin
            n_fail++;
            $display("FAIL ct_no_done: got %0d pulses required %0d", done_cnt, cnt);
        end
        // Cancel raised during the DONE cycle must not suppress completion.
        req = 3'b001;
        step(1);
        n_assert++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL ct_regrant: got %b required 001", grant);
        end
        exp_q.push_back('{3'b001, cyc + 4});
        req = 3'b000;
        step(4);
        cancel = 3'b001;
        wait_done(ok);
        n_assert++;
        e = exp_q.pop_front();
        $display("txn ct_done: done=%b cyc=%0d (want %b @%0d)", done, cyc, e.val, e.cyc);
        if (!ok || done !== e.val || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL ct_done_fires: got %b @%0d required %b @%0d", done, cyc, e.val, e.cyc);
        end
        step(1);
        cancel = 3'b000;
        n_assert++;
        if ({grant, done, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL ct_done_release: got %b required 0", {grant, done, busy});
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cancel();
        test_zero();
        test_cancel_tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
